// File: rtl/data_mem_responder.sv
// Data-port memory responder: word array with a single-entry write buffer,
// store-to-load forwarding, sub-word stores, misalignment flag and counters.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 mem_read,
    input  logic [1:0]           mem_write,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] load_count,
    output logic [CNT_WIDTH-1:0] store_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_idx;
    logic [3:0]            wb_be;
    logic [31:0]           wb_data;

    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            st_be;
    logic [31:0]           st_data;
    logic                  st_misalign;
    logic                  st_accept;
    logic [31:0]           ld_word;
    logic                  unused_addr_bits;

    assign idx              = addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    // Store decode: byte enables and lane-aligned data for the requested size
    always_comb begin
        st_be       = 4'b0000;
        st_data     = 32'h0;
        st_misalign = 1'b0;
        case (mem_write)
            2'b01: begin
                st_be   = 4'(4'b0001 << addr[1:0]);
                st_data = {4{wdata[7:0]}};
            end
            2'b10: begin
                st_misalign = addr[0];
                st_be       = addr[1] ? 4'b1100 : 4'b0011;
                st_data     = {2{wdata[15:0]}};
            end
            2'b11: begin
                st_misalign = |addr[1:0];
                st_be       = 4'b1111;
                st_data     = wdata;
            end
            default: begin
                st_be = 4'b0000;
            end
        endcase
        st_accept = (mem_write != 2'b00) && !st_misalign;
    end

    // Load word sees the array plus the older buffered entry, never this cycle's store
    always_comb begin
        ld_word = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (wb_valid && (wb_idx == idx) && wb_be[i]) begin
                ld_word[8*i +: 8] = wb_data[8*i +: 8];
            end
        end
    end

    // Array contents are never reset; commit happens one edge after capture
    always_ff @(posedge clk) begin
        if (wb_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_be[i]) begin
                    mem[wb_idx][8*i +: 8] <= wb_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_idx       <= '0;
            wb_be        <= 4'b0000;
            wb_data      <= 32'h0;
            rdata        <= 32'h0;
            rvalid       <= 1'b0;
            misalign_err <= 1'b0;
            load_count   <= '0;
            store_count  <= '0;
        end else begin
            wb_valid <= st_accept;
            if (st_accept) begin
                wb_idx  <= idx;
                wb_be   <= st_be;
                wb_data <= st_data;
            end
            rvalid <= mem_read;
            if (mem_read) begin
                rdata <= ld_word;
                if (load_count != {CNT_WIDTH{1'b1}}) begin
                    load_count <= load_count + CNT_WIDTH'(1);
                end
            end
            if (st_accept && (store_count != {CNT_WIDTH{1'b1}})) begin
                store_count <= store_count + CNT_WIDTH'(1);
            end
            if (mem_write != 2'b00 && st_misalign) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: loads push expected words,
// a negedge monitor pops and compares on every rvalid.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign_err;
    logic [15:0] load_count;
    logic [15:0] store_count;

    int checks = 0;
    int errors = 0;
    int exp_ld = 0;
    int exp_st = 0;
    logic [31:0] exp_q [$];

    data_mem_responder #(.ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .misalign_err (misalign_err),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, return #1 after the active edge
    task automatic cyc(input logic rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 2'b00;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        cyc(1'b1, 2'b00, a, 32'h0);
        if (exp_ld < 65535) exp_ld++;
    endtask

    task automatic store(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, wr, a, d);
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, "_misalign"}, 32'(misalign_err), 32'h0);
        chk({tag, "_load_count"}, 32'(load_count), 32'h0);
        chk({tag, "_store_count"}, 32'(store_count), 32'h0);
    endtask

    // Monitor: every rvalid must match the oldest outstanding expected load
    always @(negedge clk) begin
        if (rst && rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: got rdata %h with no load outstanding", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL load_data: got %h expected %h", rdata, e);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_read  = 1'b0;
        mem_write = 2'b00;
        #1 rst = 1'b0;
        #2;
        chk_zero_outputs("reset");
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Store then immediate load: forwarded from write buffer
        store(2'b11, 32'h10, 32'hDEADBEEF); exp_st++;
        load(32'h10, 32'hDEADBEEF);
        chk("rvalid_pulse_hi", 32'(rvalid), 32'h1);
        idle();
        chk("rvalid_pulse_lo", 32'(rvalid), 32'h0);
        chk("t1_store_count", 32'(store_count), 32'(exp_st));
        chk("t1_load_count", 32'(load_count), 32'(exp_ld));

        // Sub-word stores merge into one word
        store(2'b11, 32'h20, 32'h00000000); exp_st++;
        store(2'b01, 32'h21, 32'hFFFFFFAA); exp_st++;
        store(2'b10, 32'h22, 32'hFFFF1234); exp_st++;
        idle();
        load(32'h20, 32'h1234AA00);
        chk("t2_store_count", 32'(store_count), 32'(exp_st));

        // Misaligned stores are suppressed and set the sticky flag
        store(2'b11, 32'h30, 32'h30303030); exp_st++;
        store(2'b11, 32'h40, 32'h40404040); exp_st++;
        idle();
        chk("misalign_clear", 32'(misalign_err), 32'h0);
        store(2'b10, 32'h33, 32'h0000BEEF);
        chk("misalign_half", 32'(misalign_err), 32'h1);
        store(2'b11, 32'h42, 32'hBADBAD00);
        idle();
        chk("misalign_sticky", 32'(misalign_err), 32'h1);
        chk("t3_store_count", 32'(store_count), 32'(exp_st));
        load(32'h30, 32'h30303030);
        load(32'h40, 32'h40404040);

        // Same-edge load and store: load sees the old value
        store(2'b11, 32'h50, 32'h11111111); exp_st++;
        idle();
        exp_q.push_back(32'h11111111);
        cyc(1'b1, 2'b11, 32'h50, 32'h22222222); exp_st++; exp_ld++;
        load(32'h50, 32'h22222222);
        chk("t4_store_count", 32'(store_count), 32'(exp_st));
        chk("t4_load_count", 32'(load_count), 32'(exp_ld));

        // Reset while a store is still buffered discards it
        store(2'b11, 32'h60, 32'h01020304);
        idle();
        store(2'b11, 32'h60, 32'hCAFEF00D);
        rst = 1'b0;
        #2;
        chk_zero_outputs("midreset");
        @(posedge clk);
        #3 rst = 1'b1;
        exp_st = 0;
        exp_ld = 0;
        @(posedge clk);
        #1;
        load(32'h60, 32'h01020304);
        idle();
        chk("t5_misalign_after_reset", 32'(misalign_err), 32'h0);

        // Address aliasing above the index bits, then load counter saturation
        store(2'b11, 32'h0, 32'h5A5A5A5A); exp_st++;
        load(32'h1000, 32'h5A5A5A5A);
        for (int i = 0; i < 65539; i++) begin
            load(32'h1000, 32'h5A5A5A5A);
        end
        idle();
        chk("sat_load_count", 32'(load_count), 32'(exp_ld));
        chk("sat_load_count_ones", 32'(load_count), 32'h0000FFFF);
        chk("t6_store_count", 32'(store_count), 32'(exp_st));

        idle();
        idle();
        chk("outstanding_loads", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
